// File: rtl/branch_pkg.sv
// Shared condition-code and flag-index definitions for the branch unit.
package branch_pkg;

  typedef logic [3:0] cond_t;

  localparam cond_t COND_GT    = 4'b0000;
  localparam cond_t COND_LT    = 4'b0001;
  localparam cond_t COND_EQ    = 4'b0010;
  localparam cond_t COND_NE    = 4'b0011;
  localparam cond_t COND_Z     = 4'b0100;
  localparam cond_t COND_GE    = 4'b0101;
  localparam cond_t COND_LE    = 4'b0110;
  localparam cond_t COND_FLAG  = 4'b0111;
  localparam cond_t COND_NZ    = 4'b1100;
  localparam cond_t COND_NFLAG = 4'b1111;

  localparam int FLAG_EQ = 0;
  localparam int FLAG_LT = 1;
  localparam int FLAG_GT = 2;
  localparam int FLAG_Z  = 3;

endpackage

// File: rtl/branch_cond_eval.sv
// Combinational compare/select: produces the next jump decision
// and the next flags value from the operands and condition code.
module branch_cond_eval
  import branch_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic [WIDTH-1:0] rd_i,
  input  logic [WIDTH-1:0] rs_i,
  input  logic [WIDTH-1:0] n_i,
  input  cond_t            cond_i,
  input  logic             sgn_i,
  input  logic [1:0]       idx_i,
  input  logic [3:0]       flags_i,
  output logic             jump_o,
  output logic [3:0]       flags_o
);

  logic [WIDTH-1:0] b;
  logic signed [WIDTH:0] a_x, b_x;
  logic eq, lt, gt, z, fsel;

  // One extra bit lets a single signed compare serve both modes
  assign b   = cond_i[3] ? n_i : rs_i;
  assign a_x = $signed({sgn_i & rd_i[WIDTH-1], rd_i});
  assign b_x = $signed({sgn_i & b[WIDTH-1], b});

  assign eq   = (rd_i == b);
  assign lt   = (a_x < b_x);
  assign gt   = (a_x > b_x);
  assign z    = (rd_i == '0);
  assign fsel = flags_i[idx_i];

  always_comb begin
    jump_o = 1'b0;
    unique case (cond_i[2:0])
      3'b000: jump_o = gt;
      3'b001: jump_o = lt;
      3'b010: jump_o = eq;
      3'b011: jump_o = ~eq;
      3'b100: jump_o = cond_i[3] ? ~z : z;
      3'b101: jump_o = ~lt;
      3'b110: jump_o = ~gt;
      3'b111: jump_o = cond_i[3] ? ~fsel : fsel;
      default: jump_o = 1'b0;
    endcase
  end

  always_comb begin
    flags_o = flags_i;
    if (cond_i[2:0] != 3'b111)
      flags_o = {z, gt, lt, eq};
  end

endmodule

// File: rtl/branch_unit.sv
// Registered branch-condition unit with flags register.
// Define BRANCH_SIGNED_EN to honour instruction[5] as signed-compare.
module branch_unit
  import branch_pkg::*;
#(
  parameter int WIDTH   = 16,
  parameter int INSTR_W = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  input  logic               hold,
  input  logic               flush,
  input  logic [WIDTH-1:0]   rddata,
  input  logic [WIDTH-1:0]   rsdata,
  input  logic [WIDTH-1:0]   N,
  input  logic [INSTR_W-1:0] instruction,
  output logic               out_valid,
  output logic               jump,
  output logic [3:0]         flags
);

  cond_t      cond;
  logic       sgn;
  logic       jump_next;
  logic [3:0] flags_next;
  logic       valid_d, valid_q;
  logic       jump_d, jump_q;
  logic [3:0] flags_d, flags_q;

  assign cond = {instruction[11], instruction[4:2]};

`ifdef BRANCH_SIGNED_EN
  assign sgn = instruction[5];
`else
  assign sgn = 1'b0;
`endif

  branch_cond_eval #(.WIDTH(WIDTH)) u_eval (
    .rd_i    (rddata),
    .rs_i    (rsdata),
    .n_i     (N),
    .cond_i  (cond),
    .sgn_i   (sgn),
    .idx_i   (instruction[1:0]),
    .flags_i (flags_q),
    .jump_o  (jump_next),
    .flags_o (flags_next)
  );

  always_comb begin
    valid_d = valid_q;
    jump_d  = jump_q;
    flags_d = flags_q;
    if (flush) begin
      valid_d = 1'b0;
      jump_d  = 1'b0;
    end else if (!hold) begin
      valid_d = in_valid;
      jump_d  = in_valid & jump_next;
      if (in_valid)
        flags_d = flags_next;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= 1'b0;
      jump_q  <= 1'b0;
      flags_q <= 4'b0000;
    end else begin
      valid_q <= valid_d;
      jump_q  <= jump_d;
      flags_q <= flags_d;
    end
  end

  assign out_valid = valid_q;
  assign jump      = jump_q & valid_q;
  assign flags     = flags_q;

endmodule

// File: tb/tb_branch_unit.sv
// Directed bench for branch_unit with an expected-result queue.
module tb_branch_unit;

  logic        clk = 1'b0;
  logic        rst, in_valid, hold, flush;
  logic [15:0] rddata, rsdata, N, instruction;
  logic        out_valid, jump;
  logic [3:0]  flags;

  typedef struct {
    string      tag;
    logic       v;
    logic       j;
    logic [3:0] f;
  } exp_t;

  exp_t q[$];
  int   tests = 0;
  int   fails = 0;

  branch_unit #(.WIDTH(16), .INSTR_W(16)) dut (
    .clk         (clk),
    .rst         (rst),
    .in_valid    (in_valid),
    .hold        (hold),
    .flush       (flush),
    .rddata      (rddata),
    .rsdata      (rsdata),
    .N           (N),
    .instruction (instruction),
    .out_valid   (out_valid),
    .jump        (jump),
    .flags       (flags)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] ins(
    input logic [3:0] c, input logic s, input logic [1:0] idx);
    logic [15:0] w;
    w = '0;
    w[11] = c[3];
    w[4:2] = c[2:0];
    w[5] = s;
    w[1:0] = idx;
    return w;
  endfunction

  task automatic step(
    input string t,
    input logic r, input logic v, input logic h, input logic fl,
    input logic [15:0] a, input logic [15:0] b, input logic [15:0] n,
    input logic [15:0] ir,
    input logic ev, input logic ej, input logic [3:0] ef);
    exp_t e, got;
    rst = r; in_valid = v; hold = h; flush = fl;
    rddata = a; rsdata = b; N = n; instruction = ir;
    e.tag = t; e.v = ev; e.j = ej; e.f = ef;
    q.push_back(e);
    @(posedge clk);
    #1;
    got = q.pop_front();
    tests++;
    assert ({out_valid, jump, flags} === {got.v, got.j, got.f})
    else begin
      fails++;
      $error("FAIL %s: observed v=%b j=%b f=%b expected v=%b j=%b f=%b",
             got.tag, out_valid, jump, flags, got.v, got.j, got.f);
    end
  endtask

  logic       sj;
  logic [3:0] sf;

  initial begin
`ifdef BRANCH_SIGNED_EN
    sj = 1'b0; sf = 4'b0010;
`else
    sj = 1'b1; sf = 4'b0100;
`endif
    rst = 1'b1; in_valid = 1'b0; hold = 1'b0; flush = 1'b0;
    rddata = '0; rsdata = '0; N = '0; instruction = '0;

    step("rst0", 1,1,0,0, 16'hFFFF,16'h0001,0, ins(4'b0000,0,0), 0,0,4'b0000);
    step("rst1", 1,1,0,0, 16'hFFFF,16'h0001,0, ins(4'b0000,0,0), 0,0,4'b0000);
    step("gt_uns", 0,1,0,0, 16'hFFFF,16'h0001,0, ins(4'b0000,0,0), 1,1,4'b0100);
    step("gt_sgn", 0,1,0,0, 16'hFFFF,16'h0001,0, ins(4'b0000,1,0), 1,sj,sf);
    step("ge_imm", 0,1,0,0, 16'd5,16'd0,16'd5, ins(4'b1101,0,0), 1,1,4'b0001);
    step("le_imm", 0,1,0,0, 16'd5,16'd0,16'd5, ins(4'b1110,0,0), 1,1,4'b0001);
    step("ne_imm", 0,1,0,0, 16'd5,16'd0,16'd5, ins(4'b1011,0,0), 1,0,4'b0001);
    step("idle", 0,0,0,0, 16'd7,16'd7,16'd0, ins(4'b0010,0,0), 0,0,4'b0001);
    step("lt_reg", 0,1,0,0, 16'd3,16'd7,16'd0, ins(4'b0001,0,0), 1,1,4'b0010);
    step("flag_lt", 0,1,0,0, 16'd0,16'd0,16'd0, ins(4'b0111,0,1), 1,1,4'b0010);
    step("nflag_lt", 0,1,0,0, 16'd0,16'd0,16'd0, ins(4'b1111,0,1), 1,0,4'b0010);
    step("eq_reg", 0,1,0,0, 16'd9,16'd9,16'd0, ins(4'b0010,0,0), 1,1,4'b0001);
    step("hold1", 0,1,1,0, 16'd1,16'd2,16'd0, ins(4'b0010,0,0), 1,1,4'b0001);
    step("hold2", 0,1,1,0, 16'd1,16'd2,16'd0, ins(4'b0001,0,0), 1,1,4'b0001);
    step("hold3", 0,1,1,0, 16'd1,16'd2,16'd0, ins(4'b0000,0,0), 1,1,4'b0001);
    step("flush_hold", 0,1,1,1, 16'd1,16'd2,16'd0, ins(4'b0001,0,0), 0,0,4'b0001);
    step("z_reg", 0,1,0,0, 16'd0,16'd0,16'd0, ins(4'b0100,0,0), 1,1,4'b1001);
    step("nz_imm", 0,1,0,0, 16'd0,16'd0,16'd3, ins(4'b1100,0,0), 1,0,4'b1010);
    step("flag_z", 0,1,0,0, 16'd4,16'd4,16'd0, ins(4'b0111,0,3), 1,1,4'b1010);
    step("rst_mid", 1,1,1,0, 16'd9,16'd9,16'd0, ins(4'b0010,0,0), 0,0,4'b0000);
    step("flush_only", 0,1,0,1, 16'd9,16'd9,16'd0, ins(4'b0010,0,0), 0,0,4'b0000);
    step("le_reg", 0,1,0,0, 16'd2,16'd3,16'd0, ins(4'b0110,0,0), 1,1,4'b0010);
    step("gt_false", 0,1,0,0, 16'd2,16'd3,16'd0, ins(4'b0000,0,0), 1,0,4'b0010);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/branch_unit.md
# branch_unit

Registered, parametrised branch-condition unit for the CPU datapath. It compares `rddata` against either `rsdata` or the immediate `N`, in signed or unsigned mode, and produces a one-cycle-latency `jump` decision with a valid strobe. It also keeps a flags register so that later flag-test branches can reuse the most recent compare. It sits between the register-file read stage and the PC-select logic.

## Interface
Parameters:
- `WIDTH`, 16: operand width in bits for `rddata`, `rsdata` and `N`.
- `INSTR_W`, 16: instruction word width; must be at least 12.

Ports:
- `clk`, input, 1: the single clock; all state updates on the rising edge.
- `rst`, input, 1: synchronous, active-high reset.
- `in_valid`, input, 1: the operands and instruction are valid this cycle.
- `hold`, input, 1: pipeline stall; freezes all state.
- `flush`, input, 1: kills the in-flight and incoming operation.
- `rddata`, input, WIDTH: first operand.
- `rsdata`, input, WIDTH: second operand for register compares.
- `N`, input, WIDTH: immediate operand.
- `instruction`, input, INSTR_W: source of the condition fields.
- `out_valid`, output, 1: the decision is valid this cycle.
- `jump`, output, 1: take the branch; qualified by `out_valid`.
- `flags`, output, 4: stored flags as {Z, GT, LT, EQ}.

## Operation
- Condition code `cond = {instruction[11], instruction[4:2]}`.
- Operand B is `rsdata` when `cond[3]=0` and `N` when `cond[3]=1`.
- `instruction[5]` is the signed-compare bit (see Configuration).
- Conditions for `cond[2:0]`:
  - 000: GT
  - 001: LT
  - 010: EQ
  - 011: NE
  - 101: GE
  - 110: LE
- cond 0100: `rddata == 0`.
- cond 1100: `rddata != 0`.
- cond 0111 (FLAG): `jump = flags[instruction[1:0]]`.
- cond 1111 (NFLAG): `jump = ~flags[instruction[1:0]]`.
- Flag index for FLAG/NFLAG: 0=EQ, 1=LT, 2=GT, 3=Z.
- Flags register:
  - Updates on every accepted compare with cond ≠ x111.
  - Sets EQ = (A==B), LT = (A<B), GT = (A>B), Z = (A==0), where A=`rddata`.
  - FLAG and NFLAG ops do not modify flags.
- An op is accepted when `in_valid & ~hold & ~flush`.
- Priority: `rst` > `flush` > `hold`.
- On `flush`: `out_valid` is 0 on the next edge and flags are unchanged.
- On `hold`: `out_valid`, `jump` and `flags` keep their values; inputs are ignored.
- `jump` is forced to 0 whenever `out_valid` is 0.
- No arithmetic overflow is possible: compares only, no subtraction-based flags.

## Timing
- Latency is 1 cycle: an op accepted at edge t gives `out_valid=1` and `jump` during cycle t+1.
- Throughput is one op per cycle.
- Back-to-back: a FLAG op accepted at edge t+1 sees the flags written by the compare accepted at edge t. No bubble is needed.
- Cycle with no accepted op and no hold: `out_valid` goes to 0 on the next edge.
- Reset values: `out_valid=0`, `jump=0`, `flags=4'b0000`. The reset value of `flags` is independent of the `hold` value.
- Reset mid-operation: the pending decision is discarded and no `jump` is emitted.

## Configuration
- Macro `BRANCH_SIGNED_EN`:
  - Defined: `instruction[5]=1` selects two's-complement compares for GT/LT/GE/LE and the flags; `instruction[5]=0` selects unsigned.
  - Undefined: all compares are unsigned and `instruction[5]` is ignored.
- EQ, NE and Z are unaffected by the macro.

## Structure
- Package `branch_pkg` holds:
  - the condition-code localparams (COND_GT … COND_NFLAG),
  - the flag-index constants FLAG_EQ/LT/GT/Z,
  - a `cond_t` 4-bit typedef.
- Sub-module `branch_cond_eval`: a combinational compare/select returning `jump_next` and `flags_next`. The top level holds the registers, the hold/flush control and the valid pipeline.

## Test plan
- Reset: assert `rst` for 2 cycles while `in_valid=1` → `out_valid=0`, `jump=0`, `flags=0` throughout, with the first decision one cycle after `rst` falls.
- Unsigned vs signed: `rddata=16'hFFFF`, `rsdata=16'h0001`, cond GT.
  - `instruction[5]=0` → `jump=1`.
  - With `BRANCH_SIGNED_EN` and `instruction[5]=1` → `jump=0`.
  - Without the macro, `instruction[5]=1` → `jump=1`.
- Immediate GE/LE: `rddata=5`, `N=5`, cond 1101 → `jump=1`; cond 1110 → `jump=1`; cond 1011 → `jump=0`.
- Flag reuse:
  - Compare `rddata=3`, `rsdata=7` (LT) → next cycle `flags=4'b0010`.
  - Then a back-to-back FLAG op, `instruction[1:0]=01` → `jump=1`.
  - Then an NFLAG op with the same index → `jump=0`, and flags are unchanged.
- Hold/flush:
  - Accept an EQ op that gives `jump=1`, then `hold=1` for 3 cycles → `out_valid=1`, `jump=1` held.
  - `flush` with `hold` → next cycle `out_valid=0`, `jump=0`, flags still from the EQ op.
